// File: rtl/uart_lite_pkg.sv
// Shared types and constants for the uart_lite TX/RX pair.
package uart_lite_pkg;

   localparam int unsigned DEFAULT_WIDTH     = 8;
   localparam int unsigned DEFAULT_DIV_WIDTH = 16;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_e;

endpackage

// File: rtl/uart_lite_baud_cnt.sv
// Loadable down-counter; tick_c is high while the count sits at zero.
module uart_lite_baud_cnt
   import uart_lite_pkg::*;
#(
   parameter int unsigned DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 load_i,
   input  logic [DIV_WIDTH-1:0] load_val_i,
   output logic                 tick_c
);

   logic [DIV_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - DIV_WIDTH'(1);
      end
   end

   assign tick_c = (cnt_q == '0);

endmodule

// File: rtl/uart_lite_tx.sv
// UART transmit serializer: pops a FWFT FIFO and shifts start/data/parity/stop
// bits onto tx_o, chaining frames with no idle gap while data is available.
module uart_lite_tx
   import uart_lite_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter int unsigned DIV_WIDTH = DEFAULT_DIV_WIDTH,
   parameter int unsigned PARITY    = PAR_NONE,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 enable_i,
   input  logic [DIV_WIDTH-1:0] divisor_i,
   input  logic [WIDTH-1:0]     fifo_data_i,
   input  logic                 fifo_empty_i,
   output logic                 fifo_rd_o,
   output logic                 tx_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int unsigned BIT_W = 4;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     shift_q, shift_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 cnt_load, tick, pop, pop_ok, last_stop;

   uart_lite_baud_cnt #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (cnt_load),
      .load_val_i (div_d - DIV_WIDTH'(1)),
      .tick_c     (tick)
   );

   assign pop_ok    = enable_i && !fifo_empty_i;
   assign last_stop = (bit_q == BIT_W'(STOP_BITS - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state and datapath; a pop reloads word, parity and frame divisor.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      div_d    = div_q;
      bit_d    = bit_q;
      par_d    = par_q;
      cnt_load = 1'b0;
      pop      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pop_ok) begin
               pop     = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d  = ST_DATA;
               bit_d    = '0;
               cnt_load = 1'b1;
            end
         end
         ST_DATA: begin
            if (tick) begin
               cnt_load = 1'b1;
               if (bit_q == BIT_W'(WIDTH - 1)) begin
                  state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                  bit_d   = '0;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = shift_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d  = ST_STOP;
               bit_d    = '0;
               cnt_load = 1'b1;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (!last_stop) begin
                  bit_d    = bit_q + BIT_W'(1);
                  cnt_load = 1'b1;
               end else if (pop_ok) begin
                  pop     = 1'b1;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (pop) begin
         shift_d  = fifo_data_i;
         div_d    = (divisor_i == '0) ? DIV_WIDTH'(1) : divisor_i;
         par_d    = (^fifo_data_i) ^ (PARITY == PAR_ODD);
         bit_d    = '0;
         cnt_load = 1'b1;
      end
   end

   // Line level for the upcoming cycle, registered so tx_o never glitches.
   always_comb begin
      tx_d      = 1'b1;
      busy_d    = (state_d != ST_IDLE);
      fifo_rd_o = pop && rst_ni;
      done_o    = (state_q == ST_STOP) && tick && last_stop;
      unique case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = par_q;
         default:   tx_d = 1'b1;
      endcase
   end

   assign tx_o   = tx_q;
   assign busy_o = busy_q;

endmodule
